// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO. Words written with tx_valid/tx_ready
// are buffered and sent as start/data/parity/stop frames, LSB first, with
// back-to-back frames when the buffer is not empty.
module uart_tx_fifo #(
    parameter int CLKS_PER_BAUD = 1250,
    parameter int DATA_BITS     = 8,
    parameter int PARITY_MODE   = 0,
    parameter int STOP_BITS     = 1,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          nRst,
    input  logic                          tx_valid,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_ready,
    output logic                          tx_serial,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CNT_W = $clog2(CLKS_PER_BAUD);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    // Reject parameter combinations the datapath cannot represent.
    generate
        if (CLKS_PER_BAUD < 2) begin : g_bad_baud
            $error("uart_tx_fifo: CLKS_PER_BAUD must be 2 or more");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_fifo: DATA_BITS must be in 5..9");
        end
        if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
            $error("uart_tx_fifo: PARITY_MODE must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state_reg,  state_next;
    logic [CNT_W-1:0]       baud_reg,   baud_next;
    logic [BIT_W-1:0]       bit_reg,    bit_next;
    logic [DATA_BITS-1:0]   shift_reg,  shift_next;
    logic                   parity_reg, parity_next;
    logic                   serial_reg, serial_next;
    logic [PTR_W:0]         count_reg,  count_next;
    logic [PTR_W-1:0]       rd_ptr_reg, wr_ptr_reg;

    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0]   head_word;
    logic                   head_parity;
    logic                   push;
    logic                   pop;
    logic                   baud_done;

    assign tx_ready    = (count_reg != (PTR_W + 1)'(FIFO_DEPTH));
    assign push        = tx_valid && tx_ready;
    assign head_word   = mem[rd_ptr_reg];
    assign head_parity = (PARITY_MODE == 2) ? ~(^head_word) : (^head_word);
    assign baud_done   = (baud_reg == CNT_W'(CLKS_PER_BAUD - 1));

    assign tx_serial   = serial_reg;
    assign busy        = (state_reg != IDLE);
    assign fifo_count  = count_reg;

    // Buffer storage: written on accepted pushes, never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= tx_data;
        end
    end

    // FIFO pointers wrap naturally because the depth is a power of 2.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        end
    end

    // Occupancy: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + (PTR_W + 1)'(1);
        end else if (!push && pop) begin
            count_next = count_reg - (PTR_W + 1)'(1);
        end
    end

    // Frame FSM and datapath state registers.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_reg  <= IDLE;
            baud_reg   <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            parity_reg <= 1'b0;
            serial_reg <= 1'b1;
            count_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            baud_reg   <= baud_next;
            bit_reg    <= bit_next;
            shift_reg  <= shift_next;
            parity_reg <= parity_next;
            serial_reg <= serial_next;
            count_reg  <= count_next;
        end
    end

    // Next-state logic; the serial level for each bit is registered on the
    // edge that starts that bit, so the line is glitch-free.
    always_comb begin
        state_next  = state_reg;
        baud_next   = baud_reg;
        bit_next    = bit_reg;
        shift_next  = shift_reg;
        parity_next = parity_reg;
        serial_next = serial_reg;
        pop         = 1'b0;
        case (state_reg)
            IDLE: begin
                pop = (count_reg != '0);
            end
            START: begin
                if (baud_done) begin
                    baud_next   = '0;
                    bit_next    = '0;
                    serial_next = shift_reg[0];
                    state_next  = DATA;
                end else begin
                    baud_next = baud_reg + CNT_W'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_next = '0;
                    if (bit_reg == BIT_W'(DATA_BITS - 1)) begin
                        bit_next = '0;
                        if (PARITY_MODE != 0) begin
                            state_next  = PARITY;
                            serial_next = parity_reg;
                        end else begin
                            state_next  = STOP;
                            serial_next = 1'b1;
                        end
                    end else begin
                        bit_next    = bit_reg + BIT_W'(1);
                        shift_next  = shift_reg >> 1;
                        serial_next = shift_reg[1];
                    end
                end else begin
                    baud_next = baud_reg + CNT_W'(1);
                end
            end
            PARITY: begin
                if (baud_done) begin
                    baud_next   = '0;
                    bit_next    = '0;
                    serial_next = 1'b1;
                    state_next  = STOP;
                end else begin
                    baud_next = baud_reg + CNT_W'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_next = '0;
                    if (bit_reg == BIT_W'(STOP_BITS - 1)) begin
                        bit_next    = '0;
                        serial_next = 1'b1;
                        state_next  = IDLE;
                        pop         = (count_reg != '0);
                    end else begin
                        bit_next = bit_reg + BIT_W'(1);
                    end
                end else begin
                    baud_next = baud_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Popping captures the head word and its parity, so later pushes or
        // tx_data changes cannot disturb the frame being sent.
        if (pop) begin
            state_next  = START;
            baud_next   = '0;
            bit_next    = '0;
            shift_next  = head_word;
            parity_next = head_parity;
            serial_next = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: three instances (8E1, 8O1, 7N2),
// a constant vector table, hand-written corner sequences and random traffic
// checked against a queue-based model of the line waveform.
module tb_uart_tx_fifo;

    localparam int BAUD  = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic nRst;
    logic tv;
    logic [7:0] td;
    int   sel;

    logic ready_e, serial_e, busy_e; logic [2:0] count_e;
    logic ready_o, serial_o, busy_o; logic [2:0] count_o;
    logic ready_n, serial_n, busy_n; logic [2:0] count_n;

    logic m_ready, m_serial, m_busy; logic [2:0] m_count;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLKS_PER_BAUD(BAUD), .DATA_BITS(8), .PARITY_MODE(1),
                   .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_e (
        .clk(clk), .nRst(nRst), .tx_valid(tv && sel == 0), .tx_data(td),
        .tx_ready(ready_e), .tx_serial(serial_e), .busy(busy_e), .fifo_count(count_e));

    uart_tx_fifo #(.CLKS_PER_BAUD(BAUD), .DATA_BITS(8), .PARITY_MODE(2),
                   .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_o (
        .clk(clk), .nRst(nRst), .tx_valid(tv && sel == 1), .tx_data(td),
        .tx_ready(ready_o), .tx_serial(serial_o), .busy(busy_o), .fifo_count(count_o));

    uart_tx_fifo #(.CLKS_PER_BAUD(BAUD), .DATA_BITS(7), .PARITY_MODE(0),
                   .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut_n (
        .clk(clk), .nRst(nRst), .tx_valid(tv && sel == 2), .tx_data(td[6:0]),
        .tx_ready(ready_n), .tx_serial(serial_n), .busy(busy_n), .fifo_count(count_n));

    // Route the selected instance to the checker.
    always_comb begin
        m_ready = ready_e; m_serial = serial_e; m_busy = busy_e; m_count = count_e;
        case (sel)
            1: begin m_ready = ready_o; m_serial = serial_o; m_busy = busy_o; m_count = count_o; end
            2: begin m_ready = ready_n; m_serial = serial_n; m_busy = busy_n; m_count = count_n; end
            default: ;
        endcase
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of words and a queue of per-cycle line levels.
    logic [7:0] mq[$];
    bit         lq[$];
    logic       exp_serial, exp_busy;
    int         m_dbits, m_pmode, m_sbits;

    task automatic model_edge(input logic v, input logic [7:0] d);
        logic [7:0] w;
        logic       p;
        int         pre_size;
        pre_size = mq.size();
        if (lq.size() == 0 && pre_size > 0) begin
            w = mq.pop_front();
            repeat (BAUD) lq.push_back(1'b0);
            p = 1'b0;
            for (int i = 0; i < m_dbits; i++) begin
                repeat (BAUD) lq.push_back(w[i]);
                p ^= w[i];
            end
            if (m_pmode != 0) begin
                if (m_pmode == 2) p = ~p;
                repeat (BAUD) lq.push_back(p);
            end
            repeat (BAUD * m_sbits) lq.push_back(1'b1);
        end
        if (v && pre_size != DEPTH) mq.push_back(d);
        if (lq.size() > 0) begin
            exp_serial = lq.pop_front();
            exp_busy   = 1'b1;
        end else begin
            exp_serial = 1'b1;
            exp_busy   = 1'b0;
        end
    endtask

    // Observations for multi-cycle checks.
    int obs_cyc, obs_busy, obs_first, obs_last, obs_max;
    bit obs_full;

    task automatic obs_clear();
        obs_cyc = 0; obs_busy = 0; obs_first = -1; obs_last = -1; obs_max = 0; obs_full = 1'b0;
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge.
    task automatic step(input logic v, input logic [7:0] d);
        tv = v;
        td = d;
        @(posedge clk);
        model_edge(v, d);
        @(negedge clk);
        check("tx_serial", m_serial, exp_serial);
        check("busy", m_busy, exp_busy);
        check("fifo_count", m_count, mq.size());
        check("tx_ready", m_ready, mq.size() != DEPTH);
        obs_cyc++;
        if (m_busy) begin
            obs_busy++;
            if (obs_first < 0) obs_first = obs_cyc;
            obs_last = obs_cyc;
        end
        if (int'(m_count) > obs_max) obs_max = int'(m_count);
        if (!m_ready) obs_full = 1'b1;
    endtask

    task automatic select_cfg(input int k);
        sel     = k;
        m_dbits = (k == 2) ? 7 : 8;
        m_pmode = (k == 0) ? 1 : ((k == 1) ? 2 : 0);
        m_sbits = (k == 2) ? 2 : 1;
    endtask

    task automatic do_reset();
        nRst = 1'b0;
        tv   = 1'b0;
        mq.delete();
        lq.delete();
        exp_serial = 1'b1;
        exp_busy   = 1'b0;
        repeat (2) @(negedge clk);
        nRst = 1'b1;
    endtask

    typedef struct {
        int         cfg;
        logic [7:0] word;
        string      bits;   // expected line level per bit period, in order
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 8'hA5, "01010010101"};
        vecs[1] = '{1, 8'h07, "01110000001"};
        vecs[2] = '{0, 8'h07, "01110000011"};
        vecs[3] = '{2, 8'h55, "0101010111"};
        vecs[4] = '{0, 8'h00, "00000000001"};
        vecs[5] = '{1, 8'hFF, "01111111111"};
        vecs[6] = '{2, 8'h7F, "0111111111"};
        vecs[7] = '{2, 8'h80, "0000000011"};

        nRst = 1'b0; tv = 1'b0; td = 8'h00;
        select_cfg(0);
        obs_clear();
        repeat (2) @(negedge clk);
        check("rst_serial_e", serial_e, 1'b1);
        check("rst_busy_e", busy_e, 1'b0);
        check("rst_count_e", count_e, 3'd0);
        check("rst_ready_e", ready_e, 1'b1);
        check("rst_serial_o", serial_o, 1'b1);
        check("rst_busy_o", busy_o, 1'b0);
        check("rst_serial_n", serial_n, 1'b1);
        check("rst_count_n", count_n, 3'd0);

        // Single frames against constant waveforms.
        for (int v = 0; v < 8; v++) begin
            select_cfg(vecs[v].cfg);
            do_reset();
            step(1'b1, vecs[v].word);
            check("tbl_push_line", m_serial, 1'b1);
            for (int b = 0; b < vecs[v].bits.len(); b++) begin
                for (int c = 0; c < BAUD; c++) begin
                    step(1'b0, 8'h00);
                    check("tbl_bit", m_serial, vecs[v].bits.getc(b) == "1");
                    check("tbl_busy", m_busy, 1'b1);
                end
            end
            step(1'b0, 8'h00);
            check("tbl_end_busy", m_busy, 1'b0);
            check("tbl_end_line", m_serial, 1'b1);
            $display("vector %0d cfg=%0d word=%02h bits=%s", v, vecs[v].cfg, vecs[v].word, vecs[v].bits);
        end

        // Three words back to back: one continuous 132-cycle busy window.
        select_cfg(0);
        do_reset();
        obs_clear();
        step(1'b1, 8'h11); step(1'b1, 8'h22); step(1'b1, 8'h33);
        repeat (140) step(1'b0, 8'h00);
        check("b2b_busy_cycles", obs_busy, 132);
        check("b2b_busy_span", obs_last - obs_first + 1, 132);
        check("b2b_peak_count", obs_max, 2);
        $display("back-to-back: busy=%0d span=%0d peak=%0d", obs_busy, obs_last - obs_first + 1, obs_max);

        // Six pushes into a depth-4 FIFO: the sixth is dropped.
        do_reset();
        obs_clear();
        for (int i = 1; i <= 6; i++) step(1'b1, 8'(i * 17));
        repeat (240) step(1'b0, 8'h00);
        check("ovf_peak_count", obs_max, 4);
        check("ovf_saw_full", obs_full, 1'b1);
        check("ovf_busy_cycles", obs_busy, 5 * 44);
        check("ovf_idle_after", m_busy, 1'b0);
        $display("overflow: busy=%0d frames=%0d peak=%0d", obs_busy, obs_busy / 44, obs_max);

        // Asynchronous reset in the third data bit with two words queued.
        do_reset();
        step(1'b1, 8'hC3); step(1'b1, 8'h3C); step(1'b1, 8'h5A);
        repeat (12) step(1'b0, 8'h00);
        check("pre_rst_bit2", m_serial, 1'b0);
        check("pre_rst_count", m_count, 3'd2);
        @(posedge clk);
        #2 nRst = 1'b0;
        #1;
        check("arst_serial", m_serial, 1'b1);
        check("arst_busy", m_busy, 1'b0);
        check("arst_count", m_count, 3'd0);
        check("arst_ready", m_ready, 1'b1);
        mq.delete(); lq.delete(); exp_serial = 1'b1; exp_busy = 1'b0;
        @(negedge clk); @(negedge clk);
        nRst = 1'b1;
        obs_clear();
        repeat (100) step(1'b0, 8'h00);
        check("post_rst_no_frame", obs_busy, 0);
        $display("mid-frame reset: busy after release=%0d", obs_busy);

        // Random traffic with phases of light, heavy and sparse load.
        for (int k = 0; k < 3; k++) begin
            int thr;
            select_cfg(k);
            do_reset();
            for (int i = 0; i < ((k == 0) ? 1500 : 600); i++) begin
                thr = ((i / 150) % 3 == 0) ? 20 : (((i / 150) % 3 == 1) ? 80 : 5);
                step($urandom_range(0, 99) < thr, 8'($urandom));
            end
            $display("random cfg=%0d done, checks so far=%0d", k, checks);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
